bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
- Sequential shift-add-3 (double-dabble) converter that turns a 27-bit binary count into 8 packed BCD digits for the 8-digit seven-segment display driver directly downstream.
- It also produces a leading-zero blanking mask and an overflow flag.
- Uses one conversion request/done handshake, so the display stage always sees a stable, fully converted value.

Parameters:
- BIN_WIDTH, 27, width of the binary input.
- DIGITS, 8, number of BCD output digits.
- MAX_VAL is derived, not overridable: 10^DIGITS - 1 = 99,999,999.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  conversion request; sampled only in IDLE.
- bin  in  BIN_WIDTH  binary value; captured on the edge that accepts start.
- busy  out  1  high from the accept edge until done is asserted.
- done  out  1  one-cycle pulse; bcd, digit_en and overflow update on the same edge.
- bcd  out  4*DIGITS  packed BCD; digit 0 = bits [3:0], least significant.
- digit_en  out  DIGITS  per-digit enable for the display; leading zeros are 0.
- overflow  out  1  high when the last accepted bin exceeded MAX_VAL.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE; shift register and iteration counter cleared.
  - Outputs: busy=0, done=0, bcd=0, overflow=0, digit_en=0x01.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - If start=1 at a rising edge: load the binary field with bin, clear the BCD field (4*DIGITS bits), set counter=BIN_WIDTH, latch ovf_pend=(bin>MAX_VAL), set busy=1, go to SHIFT.
  - If start=0: hold; outputs keep their last values.
- SHIFT:
  - Each edge: every BCD nibble >=5 gets +3 (combinational, before the shift); then the whole {bcd,bin} register shifts left 1; counter decrements.
  - When counter reaches 0 (after exactly BIN_WIDTH shift edges), go to FINISH.
- FINISH (one edge):
  - Register bcd from the BCD field, or all-9s (0x99999999) if ovf_pend.
  - overflow <= ovf_pend; digit_en computed from the new bcd; done <= 1; busy <= 0.
  - Return to IDLE.
  - done clears on the next edge unconditionally.
- Latency: start accepted at edge 0; shifts on edges 1..27; done/bcd registered at edge 28 (BIN_WIDTH+1). The next start can be accepted at edge 29, giving a period of BIN_WIDTH+2 cycles.
- start while busy (SHIFT/FINISH): ignored, not queued; the in-flight conversion is unaffected.
- start held high continuously: back-to-back conversions, one every BIN_WIDTH+2 cycles.
- bin changing after acceptance: no effect on the current conversion.
- digit_en:
  - Bit k=1 if any digit j>=k is non-zero.
  - Bit 0 is always 1, so a value of 0 displays as a single "0".
- Outputs are stable between done pulses; the downstream display samples them freely.
- Width rule: the internal BCD field is 4*DIGITS bits. Overflowed inputs never propagate garbage, because saturation is applied at FINISH.
- Reset mid-conversion: the conversion is aborted, no done pulse is produced, and outputs revert to reset values.

Decomposition:
- Shared package/header:
  - state encoding localparams (IDLE=2'd0, SHIFT=2'd1, FINISH=2'd2);
  - BIN_WIDTH/DIGITS defaults;
  - the MAX_VAL constant;
  - counter width = clog2(BIN_WIDTH+1).
- One sub-module, bcd_digit_adj: 4-bit combinational add-3-if->=5 cell, instantiated DIGITS times in a generate loop.
- FSM, shift register, saturation and digit_en logic stay in the top module.

Test Plan:
- bin=0, start pulse -> done at edge 28 exactly; bcd=0x00000000, digit_en=0x01, overflow=0; busy high for edges 0..27.
- bin=12,345,678 -> bcd=0x12345678, digit_en=0xFF, overflow=0. Then bin=407 -> bcd=0x00000407, digit_en=0x07.
- Boundaries:
  - bin=99,999,999 -> bcd=0x99999999, overflow=0.
  - bin=100,000,000 -> bcd=0x99999999, overflow=1.
  - bin=134,217,727 -> bcd=0x99999999, overflow=1.
- start re-pulsed at edges 5 and 20 with different bin during a conversion of 42 -> ignored; single done with bcd=0x00000042. Then start held high with bin stepping 0..100 -> one done every 29 cycles, each result correct.
- rst_n driven low asynchronously mid-SHIFT (between edges) -> outputs clear immediately with no clock; no done pulse. After release, conversion of 55 -> bcd=0x00000055 with full 28-edge latency.

Source files
------------

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants for the sequential binary-to-BCD converter: state codes,
// default widths and the saturation limit helper.
package bin_to_bcd_seq_pkg;

    localparam int BIN_WIDTH_DEF = 27;
    localparam int DIGITS_DEF    = 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    // Largest value representable in the given number of decimal digits.
    function automatic logic [63:0] max_val(input int digits);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < digits; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = max_val(DIGITS_DEF);
    localparam int          CNT_W   = $clog2(BIN_WIDTH_DEF + 1);

endpackage

// File: rtl/bin_to_bcd_seq_bcd_digit_adj.sv
// Double-dabble correction cell: one BCD nibble gets +3 when it is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 converter from a binary count to packed BCD digits,
// with leading-zero blanking mask and saturation on overflow.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_WIDTH = BIN_WIDTH_DEF,
    parameter int DIGITS    = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  overflow
);

    localparam int          BCD_W     = 4 * DIGITS;
    localparam int          SR_W      = BCD_W + BIN_WIDTH;
    localparam int          CW        = $clog2(BIN_WIDTH + 1);
    localparam logic [63:0] SAT_LIMIT = max_val(DIGITS);

    logic [1:0]        state;
    logic [SR_W-1:0]   sr;
    logic [CW-1:0]     cnt;
    logic              ovf_pend;
    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W-1:0]  bcd_next;
    logic [DIGITS-1:0] en_next;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (sr[BIN_WIDTH + 4*g +: 4]),
            .digit_out (bcd_adj[4*g +: 4])
        );
    end

    // Saturate before the display mask is derived, so overflowed inputs show all nines.
    always_comb begin
        bcd_next = ovf_pend ? {DIGITS{4'h9}} : sr[SR_W-1:BIN_WIDTH];
        en_next  = '0;
        en_next[DIGITS-1] = |bcd_next[BCD_W-1 -: 4];
        for (int k = DIGITS - 2; k >= 0; k--) begin
            en_next[k] = en_next[k+1] | (|bcd_next[4*k +: 4]);
        end
        en_next[0] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
            digit_en <= DIGITS'(1);
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr       <= {{BCD_W{1'b0}}, bin};
                        cnt      <= CW'(BIN_WIDTH);
                        ovf_pend <= (64'(bin) > SAT_LIMIT);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= {bcd_adj[BCD_W-2:0], sr[BIN_WIDTH-1:0], 1'b0};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    bcd      <= bcd_next;
                    digit_en <= en_next;
                    overflow <= ovf_pend;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: table of conversions, handshake
// corner cases and a scoreboard of expected results consumed on each done pulse.
module tb_bin_to_bcd_seq;

    typedef struct {
        logic [26:0] bin;
        logic [31:0] bcd;
        logic [7:0]  en;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [26:0] bin = '0;
    logic        busy;
    logic        done;
    logic [31:0] bcd;
    logic [7:0]  digit_en;
    logic        overflow;

    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   last_done = 0;
    bit   prev_b2b = 1'b0;
    bit   b2b_mode = 1'b0;
    vec_t sb[$];
    vec_t tbl[6];

    bin_to_bcd_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .digit_en (digit_en),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic check_output(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference conversion by repeated division, independent of the shift algorithm.
    function automatic vec_t model(input int v);
        vec_t r;
        int   t;
        r.bin = v[26:0];
        r.bcd = '0;
        r.ovf = (v > 99999999);
        if (r.ovf) begin
            r.bcd = 32'h99999999;
        end else begin
            t = v;
            for (int d = 0; d < 8; d++) begin
                r.bcd[4*d +: 4] = 4'(t % 10);
                t = t / 10;
            end
        end
        for (int k = 0; k < 8; k++) begin
            r.en[k] = ((r.bcd >> (4*k)) != 32'h0);
        end
        r.en[0] = 1'b1;
        return r;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest pending request.
    always @(negedge clk) begin
        vec_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1, required no done (cycle %0d)", cycle);
            end else begin
                e = sb.pop_front();
                check_output("bcd", longint'(bcd), longint'(e.bcd));
                check_output("digit_en", longint'(digit_en), longint'(e.en));
                check_output("overflow", longint'(overflow), longint'(e.ovf));
            end
            if (b2b_mode && prev_b2b) begin
                check_output("b2b_period", longint'(cycle - last_done), 29);
            end
            prev_b2b  = b2b_mode;
            last_done = cycle;
        end
    end

    task automatic apply_stimulus(input logic [26:0] v, input vec_t exp);
        int n;
        bit busy_ok;
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = ~v;
        check_output("busy_after_accept", longint'(busy), 1);
        n = 0;
        busy_ok = 1'b1;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (!done && !busy) busy_ok = 1'b0;
        end
        check_output("latency", longint'(n), 28);
        check_output("busy_during_shift", longint'(busy_ok), 1);
        check_output("busy_cleared", longint'(busy), 0);
        @(posedge clk);
        #1;
        check_output("done_one_cycle", longint'(done), 0);
    endtask

    initial begin
        int n;

        tbl[0] = '{bin: 27'd0,         bcd: 32'h00000000, en: 8'h01, ovf: 1'b0};
        tbl[1] = '{bin: 27'd12345678,  bcd: 32'h12345678, en: 8'hFF, ovf: 1'b0};
        tbl[2] = '{bin: 27'd407,       bcd: 32'h00000407, en: 8'h07, ovf: 1'b0};
        tbl[3] = '{bin: 27'd99999999,  bcd: 32'h99999999, en: 8'hFF, ovf: 1'b0};
        tbl[4] = '{bin: 27'd100000000, bcd: 32'h99999999, en: 8'hFF, ovf: 1'b1};
        tbl[5] = '{bin: 27'd134217727, bcd: 32'h99999999, en: 8'hFF, ovf: 1'b1};

        #12;
        check_output("reset_busy", longint'(busy), 0);
        check_output("reset_done", longint'(done), 0);
        check_output("reset_bcd", longint'(bcd), 0);
        check_output("reset_digit_en", longint'(digit_en), 1);
        check_output("reset_overflow", longint'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(tbl[i].bin, tbl[i]);
        end

        // Start re-pulsed during an in-flight conversion must be dropped.
        @(negedge clk);
        bin   = 27'd42;
        start = 1'b1;
        sb.push_back(model(42));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bin   = 27'd999;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        bin   = 27'd12345;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = '0;
        n = 20;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("ignored_start_latency", longint'(n), 28);
        repeat (40) @(negedge clk);

        // Start held high: one accept every 29 edges, bin stepped per accept.
        b2b_mode = 1'b1;
        @(negedge clk);
        start = 1'b1;
        for (int v = 0; v <= 100; v++) begin
            bin = 27'(v);
            sb.push_back(model(v));
            repeat (29) @(negedge clk);
        end
        start = 1'b0;
        repeat (35) @(negedge clk);
        b2b_mode = 1'b0;

        // Asynchronous reset between edges aborts the conversion with no done.
        @(negedge clk);
        bin   = 27'd777;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_output("midreset_busy", longint'(busy), 0);
        check_output("midreset_done", longint'(done), 0);
        check_output("midreset_bcd", longint'(bcd), 0);
        check_output("midreset_digit_en", longint'(digit_en), 1);
        check_output("midreset_overflow", longint'(overflow), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        apply_stimulus(27'd55, model(55));

        repeat (5) @(negedge clk);
        check_output("scoreboard_empty", longint'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
